hb_interp2_serial: RTL and testbench
====================================

// Module: hb_interp2_serial
// PURPOSE
//  Parametrised x2 halfband interpolator: the successor to the fixed 15-tap halfband stages in the upsampling chain.
//  - Polyphase form: no zero-stuffing. Each input yields an even-phase output (symmetric-pair MAC) and then an odd-phase output (centre tap).
//  - Streaming valid/ready handshake on both sides, so stages cascade without external enable counters.
//  - One serial multiplier; coefficients are runtime-loadable; outputs round and saturate.
// PARAMETERS
//  WIDTH     18  input/output sample width, signed
//  COEF_W    18  coefficient width, signed, COEF_W-1 fractional bits
//  NTAPS     15  halfband length; must satisfy NTAPS%4==3; elaboration fails otherwise
//  ROUND      1  1 = round half-up at output; 0 = truncate
// PORTS
//  sys_clk     in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  in_data     in   WIDTH   input sample
//  in_valid    in   1       in_data valid
//  in_ready    out  1       block accepts a sample this cycle
//  out_data    out  WIDTH   interpolated sample
//  out_valid   out  1       out_data valid
//  out_ready   in   1       downstream accepts out_data
//  bypass      in   1       sampled on accept; 1 = zero-order hold (both phases = input)
//  coef_we     in   1       coefficient write strobe
//  coef_addr   in   clog2(NU+1)  0..NU-1 = pair coefs h[0],h[2],..; NU = centre tap
//  coef_wdata  in   COEF_W  coefficient value
//  coef_err    out  1       one-cycle pulse: coef write dropped (busy or addr>NU)
//  sat_flag    out  1       sticky: saturation occurred
//  sat_clr     in   1       clears sat_flag (set wins if same cycle)
// BEHAVIOUR
//  - Derived constants: D=(NTAPS+1)/2 delay-line depth; NU=(NTAPS+1)/4 pairs; CI=(NTAPS-3)/4 centre index.
//  - Reset (async):
//    - Delay line, out_data, out_valid, sat_flag and coef_err are cleared to 0.
//    - FSM enters IDLE.
//    - Pair coefs reset to 0; centre coef resets to 2^(COEF_W-1)-1.
//  - FSM states: IDLE -> MAC -> OUT_E -> OUT_O -> IDLE.
//    - IDLE: in_ready=1.
//      - in_valid&in_ready at edge k: shift in_data into x[0] (x[i]<=x[i-1]), latch bypass, clear acc, go MAC.
//    - MAC: j=0..NU-1, one per cycle.
//      - acc += h[2j]*(x[j]+x[D-1-j]).
//      - The pre-add is WIDTH+1 bits; acc is WIDTH+COEF_W+clog2(NU)+1 bits, no internal overflow.
//    - OUT_E: entered at edge k+NU+1. out_valid=1, out_data=even result.
//    - OUT_O: entered on out_valid&out_ready.
//      - out_data = centre result = hc*x[CI], computed on the same multiplier in the last MAC slot+1 and held.
//      - Handshake returns the FSM to IDLE.
//  - Output scaling includes the x2 interpolation gain.
//    - Formula: y = sat(rnd(acc >>> (COEF_W-2))).
//    - rnd adds 2^(COEF_W-3) before the shift when ROUND=1.
//    - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and sets sat_flag.
//  - Bypass: both phases output the accepted input unscaled. Latency is unchanged, the MAC still runs, and the delay line still updates.
//  - Handshake rules:
//    - out_data is stable while out_valid & !out_ready.
//    - in_ready=0 outside IDLE.
//    - Minimum period is NU+3 cycles per input when out_ready=1.
//  - in_valid while in_ready=0: the sample is not consumed; the source holds it.
//  - Coef writes are applied only in IDLE, and only with coef_addr<=NU. Any other write sets coef_err; the coef is unchanged.
//  - Coef write and accept in the same IDLE cycle: the new coef is used for that sample.
//  - Reset mid-MAC or mid-output: the in-flight sample is discarded, no output is produced, and the delay line is zeroed.
// TESTING
//  1) Default coefs + impulse:
//     - Load h=-348,3274,-15925,78535, hc=131071; ROUND=1.
//     - Feed 1024 then zeros.
//     - Pairs (even,odd): (-5,0),(51,0),(-249,0),(1227,2048),(1227,0),(-249,0),(51,0),(-5,0), then (0,0).
//  2) Saturation:
//     - Constant 131071 input with test-1 coefs.
//     - Odd outputs = 131071 and sat_flag=1.
//     - sat_clr pulse -> sat_flag=0 unless re-set the same cycle.
//  3) Backpressure:
//     - Hold out_ready=0 for 10 cycles in OUT_E -> out_data constant, in_ready=0.
//     - Release -> even then odd phase each transfer exactly once.
//  4) Bypass:
//     - bypass=1, input -7000 -> outputs -7000,-7000.
//     - Next sample with bypass=0 uses a delay line containing -7000.
//  5) Coef write during MAC -> coef_err pulse, coef unchanged. coef_addr=NU+1 in IDLE -> coef_err.
//  6) Reset asserted 2 cycles into MAC -> out_valid stays 0; after release, first output pair corresponds only to post-reset inputs.

Source files
------------

// File: rtl/hb_interp2_serial.sv
// Polyphase x2 halfband interpolator sharing one multiplier between the pair MAC and the centre tap.
// Each accepted sample yields an even-phase output followed by an odd-phase output over valid/ready.
module hb_interp2_serial #(
   parameter int WIDTH  = 18,
   parameter int COEF_W = 18,
   parameter int NTAPS  = 15,
   parameter int ROUND  = 1,
   localparam int NU    = (NTAPS + 1) / 4,
   localparam int AW    = $clog2(NU + 1)
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              bypass,
   input  logic              coef_we,
   input  logic [AW-1:0]     coef_addr,
   input  logic [COEF_W-1:0] coef_wdata,
   output logic              coef_err,
   output logic              sat_flag,
   input  logic              sat_clr
);

   localparam int D      = (NTAPS + 1) / 2;
   localparam int CI     = (NTAPS - 3) / 4;
   localparam int CW     = $clog2(NU + 1);
   localparam int PRE_W  = WIDTH + 1;
   localparam int PROD_W = PRE_W + COEF_W;
   localparam int ACC_W  = WIDTH + COEF_W + $clog2(NU) + 1;
   localparam int XW     = ACC_W + 1;
   localparam int SH     = COEF_W - 2;

   localparam logic signed [XW-1:0] RND  = (ROUND != 0) ? (XW'(1) << (COEF_W - 3)) : XW'(0);
   localparam logic signed [XW-1:0] MAXV = (XW'(1) << (WIDTH - 1)) - XW'(1);
   localparam logic signed [XW-1:0] MINV = -(XW'(1) << (WIDTH - 1));
   localparam logic [COEF_W-1:0]    HC_RST = (COEF_W'(1) << (COEF_W - 1)) - COEF_W'(1);

   if (NTAPS % 4 != 3) begin : g_bad_ntaps
      $error("hb_interp2_serial: NTAPS must satisfy NTAPS %% 4 == 3");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_OUT_E,
      S_OUT_O
   } state_t;

   state_t                   state_q;
   logic [CW-1:0]            cnt_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     byp_q;
   logic [WIDTH-1:0]         odd_q;
   logic [WIDTH-1:0]         out_data_q;
   logic                     out_valid_q;
   logic                     sat_q;
   logic                     coef_err_q;

   logic signed [WIDTH-1:0]  x_q [D];
   logic signed [COEF_W-1:0] hp_q [NU];
   logic signed [COEF_W-1:0] hc_q;

   logic                     accept;
   logic                     coef_ok;
   logic                     last_slot;
   logic                     sat_set;
   logic signed [PRE_W-1:0]  pair_sum [NU];
   logic signed [PRE_W-1:0]  pre_add;
   logic signed [COEF_W-1:0] mul_coef;
   logic signed [PROD_W-1:0] prod;
   logic [WIDTH:0]           even_res;
   logic [WIDTH:0]           odd_res;

   assign accept    = in_valid && (state_q == S_IDLE);
   assign coef_ok   = coef_we && (state_q == S_IDLE) && (coef_addr <= AW'(NU));
   assign last_slot = (state_q == S_MAC) && (cnt_q == CW'(NU));

   // Symmetric taps share a coefficient, so pre-add the mirrored samples.
   genvar gi;
   for (gi = 0; gi < NU; gi++) begin : g_pair
      assign pair_sum[gi] = PRE_W'(x_q[gi]) + PRE_W'(x_q[D-1-gi]);
   end

   // Slots 0..NU-1 feed the pair MAC; slot NU reuses the multiplier for the centre tap.
   always_comb begin
      pre_add  = PRE_W'(x_q[CI]);
      mul_coef = hc_q;
      for (int j = 0; j < NU; j++) begin
         if (cnt_q == CW'(j)) begin
            pre_add  = pair_sum[j];
            mul_coef = hp_q[j];
         end
      end
   end

   assign prod = pre_add * mul_coef;

   // Bit WIDTH of the result flags that clamping occurred.
   function automatic logic [WIDTH:0] scale_sat(input logic signed [ACC_W-1:0] v);
      logic signed [XW-1:0] r;
      r = (XW'(v) + RND) >>> SH;
      if (r > MAXV)
         return {1'b1, MAXV[WIDTH-1:0]};
      else if (r < MINV)
         return {1'b1, MINV[WIDTH-1:0]};
      else
         return {1'b0, r[WIDTH-1:0]};
   endfunction

   assign even_res = scale_sat(acc_q);
   assign odd_res  = scale_sat(ACC_W'(prod));
   assign sat_set  = last_slot && !byp_q && (even_res[WIDTH] || odd_res[WIDTH]);

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < D; i++) x_q[i] <= '0;
      end else if (accept) begin
         x_q[0] <= $signed(in_data);
         for (int i = 1; i < D; i++) x_q[i] <= x_q[i-1];
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < NU; j++) hp_q[j] <= '0;
         hc_q <= HC_RST;
      end else if (coef_ok) begin
         if (coef_addr == AW'(NU)) begin
            hc_q <= coef_wdata;
         end else begin
            for (int j = 0; j < NU; j++)
               if (coef_addr == AW'(j)) hp_q[j] <= coef_wdata;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         coef_err_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         coef_err_q <= coef_we && !coef_ok;
         if (sat_set)
            sat_q <= 1'b1;
         else if (sat_clr)
            sat_q <= 1'b0;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         byp_q       <= 1'b0;
         odd_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  byp_q   <= bypass;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_MAC;
               end
            end
            S_MAC: begin
               if (last_slot) begin
                  out_data_q  <= byp_q ? x_q[0] : even_res[WIDTH-1:0];
                  odd_q       <= byp_q ? x_q[0] : odd_res[WIDTH-1:0];
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT_E;
               end else begin
                  acc_q <= acc_q + ACC_W'(prod);
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_OUT_E: begin
               if (out_ready) begin
                  out_data_q <= odd_q;
                  state_q    <= S_OUT_O;
               end
            end
            S_OUT_O: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign coef_err  = coef_err_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_hb_interp2_serial.sv
// Self-checking bench for hb_interp2_serial against a zero-stuffed convolution reference model.
module tb_hb_interp2_serial;
   localparam int WIDTH  = 18;
   localparam int COEF_W = 18;
   localparam int NTAPS  = 15;
   localparam int NU     = (NTAPS + 1) / 4;
   localparam int AW     = $clog2(NU + 1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [WIDTH-1:0]  in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              bypass = 1'b0;
   logic              coef_we = 1'b0;
   logic [AW-1:0]     coef_addr = '0;
   logic [COEF_W-1:0] coef_wdata = '0;
   logic              coef_err;
   logic              sat_flag;
   logic              sat_clr = 1'b0;

   always #5 clk = ~clk;

   hb_interp2_serial #(.WIDTH(WIDTH), .COEF_W(COEF_W), .NTAPS(NTAPS), .ROUND(1)) dut (
      .sys_clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .bypass(bypass),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
      .sat_flag(sat_flag), .sat_clr(sat_clr)
   );

   int errors = 0;
   int checks = 0;
   int hist[$];
   int hp_m[NU];
   int hc_m;
   bit sat_m;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full-rate halfband impulse response: even taps from the pair set, centre tap, other odd taps zero.
   function automatic int hfull(int k);
      if (k == (NTAPS - 1) / 2) return hc_m;
      if (k % 2 != 0) return 0;
      return (k <= (NTAPS - 1) / 2) ? hp_m[k/2] : hp_m[(NTAPS-1-k)/2];
   endfunction

   task automatic scale_ref(input longint acc, output int y, output bit s);
      longint r;
      r = (acc + (longint'(1) <<< (COEF_W - 3))) >>> (COEF_W - 2);
      s = 1'b0;
      if (r > 131071) begin r = 131071; s = 1'b1; end
      if (r < -131072) begin r = -131072; s = 1'b1; end
      y = int'(r);
   endtask

   // Convolve the zero-stuffed input u[2m]=x[m], u[2m+1]=0 with the full response.
   task automatic model(input bit byp, output int ev, output int od);
      int m, n;
      longint ye, yo;
      bit s1, s2;
      m = hist.size() - 1;
      ye = 0;
      yo = 0;
      for (int k = 0; k < NTAPS; k++) begin
         n = 2 * m - k;
         if (n >= 0 && n % 2 == 0) ye += longint'(hfull(k)) * longint'(hist[n/2]);
         n = 2 * m + 1 - k;
         if (n >= 0 && n % 2 == 0) yo += longint'(hfull(k)) * longint'(hist[n/2]);
      end
      if (byp) begin
         ev = hist[m];
         od = hist[m];
      end else begin
         scale_ref(ye, ev, s1);
         scale_ref(yo, od, s2);
         if (s1 || s2) sat_m = 1'b1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      hist.delete();
      for (int j = 0; j < NU; j++) hp_m[j] = 0;
      hc_m = 131071;
      sat_m = 1'b0;
   endtask

   task automatic write_coef(input int addr, input int val);
      coef_addr  = AW'(addr);
      coef_wdata = COEF_W'(val);
      coef_we    = 1'b1;
      tick();
      coef_we = 1'b0;
   endtask

   task automatic load_test_coefs();
      int c[5] = '{-348, 3274, -15925, 78535, 131071};
      for (int a = 0; a <= NU; a++) write_coef(a, c[a]);
      for (int j = 0; j < NU; j++) hp_m[j] = c[j];
      hc_m = c[NU];
   endtask

   task automatic start(input int v, input bit byp);
      int n = 0;
      in_data  = WIDTH'(v);
      bypass   = byp;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin tick(); n++; end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL start_timeout: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      bypass   = 1'b0;
      hist.push_back(v);
   endtask

   task automatic collect(input bit stall, output int ev, output int od, output int lat);
      int got = 0;
      int cyc = 0;
      ev = 0;
      od = 0;
      lat = -1;
      while (got < 2 && cyc < 200) begin
         if (out_valid && lat < 0) lat = cyc;
         out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (out_valid && out_ready) begin
            if (got == 0) ev = int'($signed(out_data));
            else od = int'($signed(out_data));
            got++;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (got != 2) begin
         errors++;
         $display("FAIL collect_timeout: transfers=%0d required 2", got);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %0b required 0", sat_flag); end
      checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL reset_coef_err: got %0b required 0", coef_err); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
   endtask

   task automatic test_impulse();
      int exp_e[9] = '{-5, 51, -249, 1227, 1227, -249, 51, -5, 0};
      int exp_o[9] = '{0, 0, 0, 2048, 0, 0, 0, 0, 0};
      int ev, od, lat;
      load_test_coefs();
      for (int i = 0; i < 9; i++) begin
         start((i == 0) ? 1024 : 0, 1'b0);
         collect(1'b0, ev, od, lat);
         checks++; if (ev !== exp_e[i]) begin errors++; $display("FAIL impulse_even[%0d]: got %0d required %0d", i, ev, exp_e[i]); end
         checks++; if (od !== exp_o[i]) begin errors++; $display("FAIL impulse_odd[%0d]: got %0d required %0d", i, od, exp_o[i]); end
         checks++; if (lat !== NU + 1) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d required %0d", i, lat, NU + 1); end
      end
   endtask

   task automatic test_saturation();
      int ev, od, lat, me, mo, n;
      for (int i = 0; i < 8; i++) begin
         start(131071, 1'b0);
         model(1'b0, me, mo);
         collect(1'b0, ev, od, lat);
         checks++; if (ev !== me) begin errors++; $display("FAIL sat_even[%0d]: got %0d required %0d", i, ev, me); end
         checks++; if (od !== mo) begin errors++; $display("FAIL sat_odd[%0d]: got %0d required %0d", i, od, mo); end
      end
      checks++; if (od !== 131071) begin errors++; $display("FAIL sat_odd_clamp: got %0d required 131071", od); end
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %0b required 1", sat_flag); end
      // Clear held high across the saturating result: the set must win on that edge.
      start(131071, 1'b0);
      model(1'b0, me, mo);
      sat_clr = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %0b required 1", sat_flag); end
      sat_clr = 1'b0;
      collect(1'b0, ev, od, lat);
      checks++; if (od !== mo) begin errors++; $display("FAIL sat_odd_hold: got %0d required %0d", od, mo); end
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      sat_m = 1'b0;
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clr: got %0b required 0", sat_flag); end
   endtask

   task automatic test_backpressure();
      int me, mo, ev, od, lat, n, xfers, w, d0;
      int got[4];
      bit acc_seen;
      start(20000, 1'b0);
      model(1'b0, me, mo);
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      d0 = int'($signed(out_data));
      checks++; if (d0 !== me) begin errors++; $display("FAIL bp_even_value: got %0d required %0d", d0, me); end
      w = -12345;
      in_data  = WIDTH'(w);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if (int'($signed(out_data)) !== d0) begin errors++; $display("FAIL bp_data_stable[%0d]: got %0d required %0d", c, $signed(out_data), d0); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b required 0", c, in_ready); end
      end
      out_ready = 1'b1;
      xfers = 0;
      acc_seen = 1'b0;
      for (int c = 0; c < 10 && !acc_seen; c++) begin
         if (out_valid && out_ready) begin
            if (xfers < 4) got[xfers] = int'($signed(out_data));
            xfers++;
         end
         if (in_valid && in_ready) acc_seen = 1'b1;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if (xfers !== 2) begin errors++; $display("FAIL bp_transfer_count: got %0d required 2", xfers); end
      checks++; if (got[0] !== me) begin errors++; $display("FAIL bp_first_xfer: got %0d required %0d", got[0], me); end
      checks++; if (got[1] !== mo) begin errors++; $display("FAIL bp_second_xfer: got %0d required %0d", got[1], mo); end
      checks++; if (acc_seen !== 1'b1) begin errors++; $display("FAIL bp_held_sample_accept: got %0b required 1", acc_seen); end
      hist.push_back(w);
      model(1'b0, me, mo);
      collect(1'b0, ev, od, lat);
      checks++; if (ev !== me) begin errors++; $display("FAIL bp_held_even: got %0d required %0d", ev, me); end
      checks++; if (od !== mo) begin errors++; $display("FAIL bp_held_odd: got %0d required %0d", od, mo); end
   endtask

   task automatic test_bypass();
      int me, mo, ev, od, lat;
      start(-7000, 1'b1);
      collect(1'b0, ev, od, lat);
      checks++; if (ev !== -7000) begin errors++; $display("FAIL bypass_even: got %0d required -7000", ev); end
      checks++; if (od !== -7000) begin errors++; $display("FAIL bypass_odd: got %0d required -7000", od); end
      checks++; if (lat !== NU + 1) begin errors++; $display("FAIL bypass_latency: got %0d required %0d", lat, NU + 1); end
      start(3000, 1'b0);
      model(1'b0, me, mo);
      collect(1'b0, ev, od, lat);
      checks++; if (ev !== me) begin errors++; $display("FAIL post_bypass_even: got %0d required %0d", ev, me); end
      checks++; if (od !== mo) begin errors++; $display("FAIL post_bypass_odd: got %0d required %0d", od, mo); end
   endtask

   task automatic test_coef_err();
      int me, mo, ev, od, lat;
      start(40000, 1'b0);
      write_coef(0, 12345);
      checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL coef_err_busy: got %0b required 1", coef_err); end
      tick();
      checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL coef_err_pulse_end: got %0b required 0", coef_err); end
      model(1'b0, me, mo);
      collect(1'b0, ev, od, lat);
      checks++; if (ev !== me) begin errors++; $display("FAIL coef_busy_even: got %0d required %0d", ev, me); end
      checks++; if (od !== mo) begin errors++; $display("FAIL coef_busy_odd: got %0d required %0d", od, mo); end
      write_coef(NU + 1, 999);
      checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL coef_err_addr: got %0b required 1", coef_err); end
      write_coef(NU, 100000);
      hc_m = 100000;
      checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL coef_legal_no_err: got %0b required 0", coef_err); end
      // Coefficient write and sample accept on the same edge.
      coef_addr  = AW'(1);
      coef_wdata = COEF_W'(-2000);
      coef_we    = 1'b1;
      in_data    = WIDTH'(-50000);
      in_valid   = 1'b1;
      tick();
      coef_we  = 1'b0;
      in_valid = 1'b0;
      hp_m[1] = -2000;
      hist.push_back(-50000);
      model(1'b0, me, mo);
      collect(1'b0, ev, od, lat);
      checks++; if (ev !== me) begin errors++; $display("FAIL coef_same_cycle_even: got %0d required %0d", ev, me); end
      checks++; if (od !== mo) begin errors++; $display("FAIL coef_same_cycle_odd: got %0d required %0d", od, mo); end
      load_test_coefs();
   endtask

   task automatic test_reset_mid_mac();
      int me, mo, ev, od, lat;
      bit saw_valid = 1'b0;
      start(77777, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) saw_valid = 1'b1;
         tick();
      end
      checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midmac_out_valid: got %0b required 0", saw_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmac_in_ready: got %0b required 1", in_ready); end
      hist.delete();
      for (int j = 0; j < NU; j++) hp_m[j] = 0;
      hc_m = 131071;
      sat_m = 1'b0;
      load_test_coefs();
      for (int i = 0; i < 4; i++) begin
         start((i == 0) ? 9000 : -4000, 1'b0);
         model(1'b0, me, mo);
         collect(1'b0, ev, od, lat);
         checks++; if (ev !== me) begin errors++; $display("FAIL postreset_even[%0d]: got %0d required %0d", i, ev, me); end
         checks++; if (od !== mo) begin errors++; $display("FAIL postreset_odd[%0d]: got %0d required %0d", i, od, mo); end
      end
   endtask

   task automatic test_random();
      int v, me, mo, ev, od, lat;
      bit byp;
      for (int i = 0; i < 30; i++) begin
         v = int'($urandom_range(0, 262143)) - 131072;
         byp = ($urandom_range(0, 4) == 0);
         start(v, byp);
         model(byp, me, mo);
         collect(1'b1, ev, od, lat);
         checks++; if (ev !== me) begin errors++; $display("FAIL rand_even[%0d]: got %0d required %0d", i, ev, me); end
         checks++; if (od !== mo) begin errors++; $display("FAIL rand_odd[%0d]: got %0d required %0d", i, od, mo); end
         checks++; if (lat !== NU + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, NU + 1); end
      end
      checks++; if (sat_flag !== sat_m) begin errors++; $display("FAIL rand_sat_flag: got %0b required %0b", sat_flag, sat_m); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_saturation();
      test_backpressure();
      test_bypass();
      test_coef_err();
      test_reset_mid_mac();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
